inv_round_key_mix_seq: RTL and testbench

//   Upstream feeder for the column-wise InvMixColumns unit (inverse_matrix_mul) in the AES decrypt datapath.

---
 rtl/inv_round_key_mix_seq.sv | 158 +++++++++++++++
 tb/tb_inv_round_key_mix_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_key_mix_seq.sv
// AES decrypt round feeder: AddRoundKey followed by a column-serial pass
// through a single InvMixColumns column unit, then a handshaked result.
// The final decrypt round bypasses the column mix entirely.

// Single-column InvMixColumns: multiplies one 32-bit column by the
// inverse MixColumns matrix {0E 0B 0D 09} (rows rotated) over GF(2^8).
module inverse_matrix_mul (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  // Byte 0 is the most significant byte of the column.
  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    col_o = {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
             m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
             m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
             m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
  end

endmodule

module inv_round_key_mix_seq #(
  parameter int NB     = 4,
  parameter int WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB*WORD_W-1:0]   state_in,
  input  logic [NB*WORD_W-1:0]   round_key,
  input  logic                   skip_mix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB*WORD_W-1:0]   state_out,
  output logic                   busy
);

  localparam int STATE_W = NB * WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         col_cnt_q;
  logic [STATE_W-1:0] buf_q;
  logic               skip_q;
  logic               out_valid_q;

  logic [WORD_W-1:0]  mix_in;
  logic [WORD_W-1:0]  mix_col_d;

  // Pick the column currently being mixed; column 0 sits in the top word.
  always_comb begin
    mix_in = buf_q[127:96];
    case (col_cnt_q)
      2'd1:    mix_in = buf_q[95:64];
      2'd2:    mix_in = buf_q[63:32];
      2'd3:    mix_in = buf_q[31:0];
      default: mix_in = buf_q[127:96];
    endcase
  end

  inverse_matrix_mul u_imm (
    .col_i (mix_in),
    .col_o (mix_col_d)
  );

  // Sequencer: key fold on accept, one column mixed per clock, then hold the
  // result until the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      buf_q       <= '0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q     <= state_in ^ round_key;
            skip_q    <= skip_mix;
            col_cnt_q <= 2'd0;
            if (skip_mix) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= MIX;
            end
          end
        end
        MIX: begin
          // MIX is only entered with skip_q clear; the guard keeps a bypassed
          // state from ever being written by the column unit.
          if (!skip_q) begin
            case (col_cnt_q)
              2'd0:    buf_q[127:96] <= mix_col_d;
              2'd1:    buf_q[95:64]  <= mix_col_d;
              2'd2:    buf_q[63:32]  <= mix_col_d;
              default: buf_q[31:0]   <= mix_col_d;
            endcase
          end
          col_cnt_q <= col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = out_valid_q;
  assign state_out = buf_q;

endmodule

// File: tb/tb_inv_round_key_mix_seq.sv
// Bench for inv_round_key_mix_seq: directed AES vectors plus randomized
// traffic, with a queue-based scoreboard fed by the driver and drained by an
// independent monitor.
module tb_inv_round_key_mix_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         skip_mix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  inv_round_key_mix_seq #(.NB(4), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .skip_mix  (skip_mix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  logic [127:0] exp_q[$];
  int           lat_q[$];

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V3_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V3_OUT = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom % 2);
    else               out_ready = (rdy_mode == 1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: GF(2^8) product by shift-and-add, then the inverse matrix
  // applied column by column.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0]  a [4];
    logic [7:0]  coef [4];
    logic [31:0] r = '0;
    logic [7:0]  o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
    for (int row = 0; row < 4; row++) begin
      o = 8'h00;
      for (int c = 0; c < 4; c++) o ^= gmul(a[c], coef[(c - row + 4) % 4]);
      r[31-8*row -: 8] = o;
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic sk);
    logic [127:0] x = s ^ k;
    if (!sk)
      for (int j = 0; j < 4; j++) x[127-32*j -: 32] = inv_mix(x[127-32*j -: 32]);
    return x;
  endfunction

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic sk,
                      input logic [127:0] exp);
    bit rdy = 1'b0;
    int e = 0;
    int n = 0;
    state_in = s; round_key = k; skip_mix = sk; in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      e = edge_cnt;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      exp_q.push_back(exp);
      lat_q.push_back(e + 1 + (sk ? 0 : 4));
    end
    #1;
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    skip_mix = 1'($urandom % 2);
  endtask

  // Monitor: output rise timing, stall stability, and result scoreboard.
  logic         prev_vld = 1'b0;
  logic         prev_hs = 1'b0;
  logic [127:0] prev_out = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      prev_hs = 1'b0;
    end else begin
      chk("busy_vs_in_ready", {127'd0, busy}, {127'd0, !in_ready});
      if (out_valid && !prev_vld) begin
        if (lat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0");
        end else begin
          chk("out_valid_rise_edge", 128'(edge_cnt), 128'(lat_q.pop_front()));
        end
      end
      if (out_valid && prev_vld && !prev_hs)
        chk("stall_stable", state_out, prev_out);
      if (out_valid)
        chk("in_ready_low_in_done", {127'd0, in_ready}, 128'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%h required=none", state_out);
        end else begin
          chk("state_out", state_out, exp_q.pop_front());
        end
      end
      prev_vld = out_valid;
      prev_out = state_out;
      prev_hs  = out_valid && out_ready;
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    logic [127:0] s, k;
    logic sk;
    rst = 1'b1; in_valid = 1'b0; state_in = '0; round_key = '0; skip_mix = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_state_out", state_out, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    @(posedge clk); #1;

    // Mix vector, key fold, final-round bypass, model agreement.
    send(V1_IN, 128'd0, 1'b0, V1_OUT);
    send(128'd0, V1_IN, 1'b0, V1_OUT);
    send(V3_IN, V3_KEY, 1'b1, V3_OUT);
    chk("model_mix_vector", model(V1_IN, 128'd0, 1'b0), V1_OUT);
    chk("model_skip_vector", model(V3_IN, V3_KEY, 1'b1), V3_OUT);

    // Input activity during MIX must be ignored.
    send(V1_IN, 128'd0, 1'b0, V1_OUT);
    in_valid = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;

    // Backpressure: result held in DONE for 10 cycles.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1 rdy_mode = 0; out_ready = 1'b0;
    send(V1_IN, 128'd0, 1'b0, V1_OUT);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_state_out", state_out, V1_OUT);
    end
    @(posedge clk); #1 rdy_mode = 1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_release_out_valid", {127'd0, out_valid}, 128'd0);

    // Reset with col_cnt==2 discards the in-flight state.
    @(posedge clk); #1;
    send({$urandom, $urandom, $urandom, $urandom}, 128'd0, 1'b0, 128'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midreset_state_out", state_out, 128'd0);
    chk("midreset_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    send(V1_IN, 128'd0, 1'b0, V1_OUT);

    // Random traffic with random downstream readiness.
    rdy_mode = 2;
    repeat (40) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      sk = 1'($urandom % 2);
      send(s, k, sk, model(s, k, sk));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    chk("drain_results", 128'(exp_q.size()), 128'd0);
    chk("drain_latency", 128'(lat_q.size()), 128'd0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
